// File: rtl/fir_requant_decim.sv
// Decimating requantizer for a full-precision FIR output: keeps one sample in DECIM,
// rounds half-up, shifts down to OW bits with saturation, and queues results in a FWFT FIFO.
module fir_requant_decim #(
    parameter int IW    = 37,
    parameter int OW    = 16,
    parameter int SHIFT = 21,
    parameter int DECIM = 4,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [IW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_data,
    output logic          sat,
    output logic          overrun,
    input  logic          flag_clr
);

    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);
    localparam logic [AW:0]   FULL_CNT   = (AW + 1)'(DEPTH);
    localparam logic signed [IW:0] ONE  = {{IW{1'b0}}, 1'b1};
    localparam logic signed [IW:0] HALF = ONE <<< (SHIFT - 1);
    localparam logic signed [IW:0] QMAX = (ONE <<< (OW - 1)) - ONE;
    localparam logic signed [IW:0] QMIN = ~QMAX;

    // Result is {saturated, value}; the shift happens in IW+1 bits so the rounding add cannot wrap.
    function automatic logic [OW:0] requant(input logic signed [IW:0] r);
        logic signed [IW:0] q;
        q = r >>> SHIFT;
        if (q > QMAX) begin
            requant = {1'b1, QMAX[OW-1:0]};
        end else if (q < QMIN) begin
            requant = {1'b1, QMIN[OW-1:0]};
        end else begin
            requant = {1'b0, q[OW-1:0]};
        end
    endfunction

    logic [PW-1:0]      phase_r;
    logic               s1_valid_r;
    logic signed [IW:0] s1_data_r;
    logic [OW-1:0]      mem_r [DEPTH];
    logic [AW-1:0]      wr_ptr_r;
    logic [AW-1:0]      rd_ptr_r;
    logic [AW:0]        count_r;
    logic               out_valid_r;
    logic               sat_r;
    logic               overrun_r;

    logic               keep_s;
    logic [OW:0]        rq_s;
    logic               pop_s;
    logic               full_s;
    logic               wr_s;
    logic               drop_s;
    logic               sat_evt_s;
    logic [AW:0]        count_nxt_s;

    // Keep/pop/write decisions and next occupancy.
    always_comb begin
        keep_s    = in_valid && (phase_r == {PW{1'b0}});
        rq_s      = requant(s1_data_r);
        pop_s     = out_valid_r && out_ready;
        full_s    = (count_r == FULL_CNT);
        wr_s      = s1_valid_r && (!full_s || pop_s);
        drop_s    = s1_valid_r && full_s && !pop_s;
        sat_evt_s = s1_valid_r && rq_s[OW];
        case ({wr_s, pop_s})
            2'b10:   count_nxt_s = count_r + (AW + 1)'(1);
            2'b01:   count_nxt_s = count_r - (AW + 1)'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Decimation phase and stage-1 rounding register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            phase_r    <= {PW{1'b0}};
            s1_valid_r <= 1'b0;
        end else begin
            if (in_valid) begin
                phase_r <= (phase_r == PHASE_LAST) ? {PW{1'b0}} : phase_r + PW'(1);
            end
            s1_valid_r <= keep_s;
        end
    end

    // Stage-1 data needs no reset; it is qualified by s1_valid_r.
    always_ff @(posedge clk) begin
        if (keep_s) begin
            s1_data_r <= $signed({in_data[IW-1], in_data}) + HALF;
        end
    end

    // FIFO storage, written by stage 2.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[wr_ptr_r] <= rq_s[OW-1:0];
        end
    end

    // FIFO pointers, occupancy and sticky status flags; a new event beats flag_clr.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            count_r     <= {(AW + 1){1'b0}};
            out_valid_r <= 1'b0;
            sat_r       <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r     <= count_nxt_s;
            out_valid_r <= (count_nxt_s != {(AW + 1){1'b0}});
            if (sat_evt_s) begin
                sat_r <= 1'b1;
            end else if (flag_clr) begin
                sat_r <= 1'b0;
            end
            if (drop_s) begin
                overrun_r <= 1'b1;
            end else if (flag_clr) begin
                overrun_r <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = mem_r[rd_ptr_r];
    assign sat       = sat_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_fir_requant_decim.sv
// Directed scoreboard bench: a DECIM=1 instance (IW widened to 40 so +/-40000 fits before
// the shift) and a default DECIM=4 instance; outputs are popped and compared on the falling edge.
module tb_fir_requant_decim;

    localparam int IW1 = 40;

    logic clk;
    logic rst;
    logic flag_clr;

    logic                  in_valid1;
    logic [IW1-1:0]        in_data1;
    logic                  out_valid1;
    logic                  out_ready1;
    logic signed [15:0]    out_data1;
    logic                  sat1;
    logic                  overrun1;

    logic                  in_valid4;
    logic [36:0]           in_data4;
    logic                  out_valid4;
    logic                  out_ready4;
    logic signed [15:0]    out_data4;
    logic                  sat4;
    logic                  overrun4;

    logic signed [15:0] exp1 [$];
    logic signed [15:0] exp4 [$];

    int total = 0;
    int bad   = 0;

    fir_requant_decim #(.IW(IW1), .OW(16), .SHIFT(21), .DECIM(1), .DEPTH(4)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .sat(sat1), .overrun(overrun1), .flag_clr(flag_clr)
    );

    fir_requant_decim u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_data(in_data4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
        .sat(sat4), .overrun(overrun4), .flag_clr(flag_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic logic [IW1-1:0] sc1(input longint v, input int sh);
        return IW1'(v <<< sh);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send1(input longint v, input int sh, input logic signed [15:0] e, input bit push);
        in_valid1 = 1'b1;
        in_data1  = sc1(v, sh);
        if (push) exp1.push_back(e);
        tick();
        in_valid1 = 1'b0;
    endtask

    task automatic send4(input longint v, input bit push);
        in_valid4 = 1'b1;
        in_data4  = 37'(v <<< 21);
        if (push) exp4.push_back(16'(v));
        tick();
        in_valid4 = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && (exp1.size() != 0 || exp4.size() != 0 ||
                                   out_valid1 === 1'b1 || out_valid4 === 1'b1); i++) begin
            tick();
        end
        check({tag, "_valid1"}, out_valid1, 0);
        check({tag, "_left1"}, exp1.size(), 0);
        check({tag, "_left4"}, exp4.size(), 0);
    endtask

    // Scoreboard: whatever is presented while the consumer is ready must be the next expected sample.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (out_valid1 === 1'b1 && out_ready1 === 1'b1) begin
                if (exp1.size() == 0) check("unexpected1", out_data1, 99999);
                else check("data1", out_data1, exp1.pop_front());
            end
            if (out_valid4 === 1'b1 && out_ready4 === 1'b1) begin
                if (exp4.size() == 0) check("unexpected4", out_data4, 99999);
                else check("data4", out_data4, exp4.pop_front());
            end
        end
    end

    initial begin
        rst        = 1'b0;
        flag_clr   = 1'b0;
        in_valid1  = 1'b0;
        in_data1   = '0;
        out_ready1 = 1'b1;
        in_valid4  = 1'b0;
        in_data4   = '0;
        out_ready4 = 1'b1;
        repeat (3) tick();
        check("rst_valid1", out_valid1, 0);
        check("rst_sat1", sat1, 0);
        check("rst_overrun1", overrun1, 0);
        check("rst_valid4", out_valid4, 0);
        rst = 1'b1;
        tick();

        // Basic sample and two-cycle latency.
        send1(3, 21, 16'sd3, 1'b1);
        check("lat_early", out_valid1, 0);
        tick();
        check("lat_valid", out_valid1, 1);
        check("lat_sat", sat1, 0);
        drain("basic");

        // Round half-up, back-to-back, plus in-range extremes.
        send1(5, 20, 16'sd3, 1'b1);
        send1(-5, 20, -16'sd2, 1'b1);
        send1((longint'(1) <<< 20) - 1, 0, 16'sd0, 1'b1);
        send1(32767, 21, 16'sd32767, 1'b1);
        send1(-32768, 21, -16'sd32768, 1'b1);
        drain("round");
        check("round_sat", sat1, 0);

        // Saturation and sticky flag.
        send1(40000, 21, 16'sd32767, 1'b1);
        drain("satp");
        check("satp_flag", sat1, 1);
        send1(-40000, 21, -16'sd32768, 1'b1);
        drain("satn");
        check("satn_flag", sat1, 1);
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        check("sat_clr", sat1, 0);
        // flag_clr on the same edge as a saturating write loses.
        in_valid1 = 1'b1;
        in_data1  = sc1(-40000, 21);
        exp1.push_back(-16'sd32768);
        tick();
        in_valid1 = 1'b0;
        flag_clr  = 1'b1;
        tick();
        flag_clr  = 1'b0;
        check("sat_wins", sat1, 1);
        drain("satw");
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        check("sat_clr2", sat1, 0);

        // Decimation by 4 with random gaps.
        for (int i = 1; i <= 8; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            send4(i, ((i - 1) % 4) == 0);
        end
        drain("decim");

        // Overrun: five samples into a stalled 4-deep FIFO.
        out_ready1 = 1'b0;
        for (int v = 10; v <= 14; v++) send1(v, 21, 16'(v), v < 14);
        repeat (2) tick();
        check("ovr_flag", overrun1, 1);
        check("ovr_valid", out_valid1, 1);
        out_ready1 = 1'b1;
        drain("ovr");
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        check("ovr_clr", overrun1, 0);

        // Write into a full FIFO on the same edge as a pop is accepted.
        out_ready1 = 1'b0;
        for (int v = 20; v <= 23; v++) send1(v, 21, 16'(v), 1'b1);
        tick();
        send1(24, 21, 16'sd24, 1'b1);
        out_ready1 = 1'b1;
        tick();
        check("fullpop_ovr", overrun1, 0);
        drain("fullpop");
        check("fullpop_ovr2", overrun1, 0);

        // Reset mid-stream: stored and in-flight samples vanish, phase restarts at 0.
        send4(40, 1'b1);
        send4(41, 1'b0);
        drain("pre_rst");
        out_ready1 = 1'b0;
        send1(30, 21, 16'sd30, 1'b0);
        send1(31, 21, 16'sd31, 1'b0);
        in_valid1 = 1'b1;
        in_data1  = sc1(33, 21);
        rst       = 1'b0;
        tick();
        in_valid1 = 1'b0;
        check("mrst_valid1", out_valid1, 0);
        check("mrst_valid4", out_valid4, 0);
        rst = 1'b1;
        out_ready1 = 1'b1;
        tick();
        check("mrst_after", out_valid1, 0);
        send1(32, 21, 16'sd32, 1'b1);
        send4(42, 1'b1);
        drain("mrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
